// File: rtl/refill_way_sched_pkg.sv
// refill_way_sched_pkg: shared FSM states, LFSR taps and helpers for the refill victim scheduler
package refill_way_sched_pkg;

    localparam int MAX_WAYS = 8;
    // Taps on bits 7,3,2,1; feedback is the inverted XOR so an all-zero seed still advances
    localparam logic [7:0] LFSR_TAPS = 8'b1000_1110;

    typedef enum logic [1:0] {IDLE, SELECT, RESP} state_t;

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ~^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [2:0] oh2bin(input logic [MAX_WAYS-1:0] oh);
        logic [2:0] b;
        b = '0;
        for (int i = 0; i < MAX_WAYS; i++)
            b = oh[i] ? b | 3'(i) : b;
        return b;
    endfunction

endpackage

// File: rtl/refill_way_sched_first_one_oh.sv
// first_one_oh: isolates the lowest set bit of a vector and flags whether any bit is set
module first_one_oh #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_vec,
    output logic [W-1:0] o_oh,
    output logic         o_any
);

    assign o_oh  = i_vec & (~i_vec + W'(1));
    assign o_any = |i_vec;

endmodule

// File: rtl/refill_way_sched.sv
// refill_way_sched: picks a refill victim way (invalid first, then LFSR-random, then lowest unlocked)
module refill_way_sched
    import refill_way_sched_pkg::*;
#(
    parameter int         WAYS      = 8,
    parameter logic [7:0] SEED      = 8'h00,
    parameter int         MAX_TRIES = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    input  logic [WAYS-1:0]         valid_ways_i,
    input  logic [WAYS-1:0]         lock_ways_i,
    output logic                    resp_valid_o,
    input  logic                    resp_ready_i,
    output logic [WAYS-1:0]         way_oh_o,
    output logic [$clog2(WAYS)-1:0] way_bin_o,
    output logic                    resp_invalid_o,
    output logic                    resp_err_o
);

    localparam int BW = $clog2(WAYS);
    localparam int TW = $clog2(MAX_TRIES + 1);

    if (!(WAYS == 2 || WAYS == 4 || WAYS == 8)) begin : g_bad_ways
        $fatal(1, "refill_way_sched: WAYS must be 2, 4 or 8");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 16) begin : g_bad_tries
        $fatal(1, "refill_way_sched: MAX_TRIES must be 1..16");
    end

    state_t          r_state, w_next;
    logic [WAYS-1:0] r_valid, r_lock;
    logic [7:0]      r_lfsr;
    logic [TW-1:0]   r_tries;
    logic [BW-1:0]   r_bin;
    logic            r_inv, r_err;

    logic [WAYS-1:0] w_free_oh, w_unl_oh;
    logic            w_free_any, w_unl_any;
    logic [BW-1:0]   w_cand, w_bin;
    logic            w_inv, w_err, w_step, w_retry, w_done;

    first_one_oh #(.W(WAYS)) u_free (
        .i_vec (~r_lock & ~r_valid),
        .o_oh  (w_free_oh),
        .o_any (w_free_any)
    );

    first_one_oh #(.W(WAYS)) u_unl (
        .i_vec (~r_lock),
        .o_oh  (w_unl_oh),
        .o_any (w_unl_any)
    );

    assign w_cand = r_lfsr[BW-1:0];

    // Priority: free invalid way, all-locked error, exhausted-tries fallback, random candidate
    always_comb begin
        w_bin   = '0;
        w_inv   = 1'b0;
        w_err   = 1'b0;
        w_step  = 1'b0;
        w_retry = 1'b0;
        w_done  = 1'b0;
        if (w_free_any) begin
            w_bin  = BW'(oh2bin(MAX_WAYS'(w_free_oh)));
            w_inv  = 1'b1;
            w_done = 1'b1;
        end else if (!w_unl_any) begin
            w_err  = 1'b1;
            w_done = 1'b1;
        end else if (r_tries == TW'(MAX_TRIES)) begin
            w_bin  = BW'(oh2bin(MAX_WAYS'(w_unl_oh)));
            w_done = 1'b1;
        end else begin
            w_step  = 1'b1;
            w_bin   = w_cand;
            w_done  = !r_lock[w_cand];
            w_retry = r_lock[w_cand];
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = req_valid_i ? SELECT : IDLE;
            SELECT:  w_next = w_done ? RESP : SELECT;
            RESP:    w_next = resp_ready_i ? IDLE : RESP;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid <= '0;
            r_lock  <= '0;
            r_lfsr  <= SEED;
            r_tries <= '0;
            r_bin   <= '0;
            r_inv   <= 1'b0;
            r_err   <= 1'b0;
        end else if (r_state == IDLE && req_valid_i) begin
            r_valid <= valid_ways_i;
            r_lock  <= lock_ways_i;
            r_tries <= '0;
        end else if (r_state == SELECT) begin
            if (w_step)
                r_lfsr <= lfsr_next(r_lfsr);
            if (w_retry)
                r_tries <= r_tries + TW'(1);
            if (w_done) begin
                r_bin <= w_bin;
                r_inv <= w_inv;
                r_err <= w_err;
            end
        end
    end

    assign req_ready_o    = r_state == IDLE;
    assign resp_valid_o   = r_state == RESP;
    assign way_bin_o      = resp_valid_o ? r_bin : '0;
    assign way_oh_o       = (resp_valid_o && !r_err) ? WAYS'(1) << r_bin : '0;
    assign resp_invalid_o = resp_valid_o & r_inv;
    assign resp_err_o     = resp_valid_o & r_err;

endmodule

// File: tb/tb_refill_way_sched.sv
// tb_refill_way_sched: directed vectors on two 4-way schedulers (MAX_TRIES 8 and 1)
module tb_refill_way_sched;

    logic       clk = 1'b0;
    logic       rst_a = 1'b1, rst_b = 1'b1;
    logic       req_valid = 1'b0, resp_ready = 1'b0;
    logic [3:0] valid_ways = '0, lock_ways = '0;
    logic       sel = 1'b0;

    logic       rdy_a, rv_a, inv_a, err_a, rdy_b, rv_b, inv_b, err_b;
    logic [3:0] oh_a, oh_b;
    logic [1:0] bin_a, bin_b;

    logic       m_rdy, m_rv, m_inv, m_err;
    logic [3:0] m_oh;
    logic [1:0] m_bin;
    logic [7:0] m_lfsr;

    int n_chk = 0, n_fail = 0;

    refill_way_sched #(.WAYS(4), .SEED(8'h00), .MAX_TRIES(8)) dut (
        .clk_i(clk), .rst_i(rst_a), .req_valid_i(req_valid), .req_ready_o(rdy_a),
        .valid_ways_i(valid_ways), .lock_ways_i(lock_ways), .resp_valid_o(rv_a),
        .resp_ready_i(resp_ready), .way_oh_o(oh_a), .way_bin_o(bin_a),
        .resp_invalid_o(inv_a), .resp_err_o(err_a)
    );

    refill_way_sched #(.WAYS(4), .SEED(8'h00), .MAX_TRIES(1)) dut1 (
        .clk_i(clk), .rst_i(rst_b), .req_valid_i(req_valid), .req_ready_o(rdy_b),
        .valid_ways_i(valid_ways), .lock_ways_i(lock_ways), .resp_valid_o(rv_b),
        .resp_ready_i(resp_ready), .way_oh_o(oh_b), .way_bin_o(bin_b),
        .resp_invalid_o(inv_b), .resp_err_o(err_b)
    );

    assign m_rdy  = sel ? rdy_b : rdy_a;
    assign m_rv   = sel ? rv_b  : rv_a;
    assign m_inv  = sel ? inv_b : inv_a;
    assign m_err  = sel ? err_b : err_a;
    assign m_oh   = sel ? oh_b  : oh_a;
    assign m_bin  = sel ? bin_b : bin_a;
    assign m_lfsr = sel ? dut1.r_lfsr : dut.r_lfsr;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        if (sel) rst_b = 1'b1; else rst_a = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (sel) rst_b = 1'b0; else rst_a = 1'b0;
        chk("rst.rdy", m_rdy, 1);
        chk("rst.rv", m_rv, 0);
        chk("rst.oh", m_oh, 0);
        chk("rst.lfsr", m_lfsr, 8'h00);
    endtask

    task automatic do_req(input string tag, input logic [3:0] v, input logic [3:0] l,
                          input logic [1:0] eb, input logic ei, input logic ee,
                          input int elat, input logic [7:0] elf, input int hold);
        int lat;
        logic [3:0] eoh;
        eoh = ee ? 4'b0000 : 4'b0001 << eb;
        req_valid = 1'b1;
        valid_ways = v;
        lock_ways = l;
        chk({tag, ".rdy"}, m_rdy, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk({tag, ".busy"}, m_rdy, 0);
        lat = 1;
        while (!m_rv && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".lat"}, lat, elat);
        chk({tag, ".bin"}, m_bin, eb);
        chk({tag, ".oh"}, m_oh, eoh);
        chk({tag, ".inv"}, m_inv, ei);
        chk({tag, ".err"}, m_err, ee);
        chk({tag, ".lfsr"}, m_lfsr, elf);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold.rv"}, m_rv, 1);
            chk({tag, ".hold.oh"}, m_oh, eoh);
            chk({tag, ".hold.bin"}, m_bin, eb);
            chk({tag, ".hold.err"}, m_err, ee);
            chk({tag, ".hold.rdy"}, m_rdy, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk({tag, ".post.rv"}, m_rv, 0);
        chk({tag, ".post.rdy"}, m_rdy, 1);
        chk({tag, ".post.oh"}, m_oh, 0);
        chk({tag, ".post.inv"}, m_inv, 0);
    endtask

    initial begin
        sel = 1'b0;
        do_reset();
        do_req("rnd0", 4'b1111, 4'b0000, 2'd0, 1'b0, 1'b0, 2, 8'h01, 0);
        do_req("rnd1", 4'b1111, 4'b0000, 2'd1, 1'b0, 1'b0, 2, 8'h03, 0);
        do_req("rnd2", 4'b1111, 4'b0000, 2'd3, 1'b0, 1'b0, 2, 8'h06, 0);
        do_req("rnd3", 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0, 2, 8'h0D, 0);
        do_reset();
        do_req("inv", 4'b1011, 4'b0000, 2'd2, 1'b1, 1'b0, 2, 8'h00, 0);
        do_req("invlk", 4'b0000, 4'b0001, 2'd1, 1'b1, 1'b0, 2, 8'h00, 0);
        do_reset();
        do_req("retry", 4'b1111, 4'b0001, 2'd1, 1'b0, 1'b0, 3, 8'h03, 0);
        do_req("alllk", 4'b1111, 4'b1111, 2'd0, 1'b0, 1'b1, 2, 8'h03, 5);

        rst_a = 1'b1;
        sel = 1'b1;
        do_reset();
        do_req("fallbk", 4'b1111, 4'b0011, 2'd2, 1'b0, 1'b0, 3, 8'h01, 0);
        req_valid = 1'b1;
        valid_ways = 4'b1111;
        lock_ways = 4'b0011;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        rst_b = 1'b0;
        chk("abort.rv", m_rv, 0);
        chk("abort.rdy", m_rdy, 1);
        chk("abort.lfsr", m_lfsr, 8'h00);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("abort.idle.rv", m_rv, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/refill_way_sched.md
REFILL_WAY_SCHED -- requirements
Module: refill_way_sched

Interface
REQ-001 SHALL have parameter WAYS, default 8, meaning number of cache ways; legal values 2, 4 or 8.
REQ-002 SHALL have parameter SEED, default 8'h00, meaning the LFSR reset value.
REQ-003 SHALL have parameter MAX_TRIES, default 8, meaning the number of random-candidate attempts before fallback; legal range 1..16.
REQ-004 clk_i  in  1  sole clock; all logic is on the rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 req_valid_i  in  1  victim-selection request.
REQ-007 req_ready_o  out  1  scheduler can accept a request.
REQ-008 valid_ways_i  in  WAYS  per-way valid bits of the addressed set; sampled on accept.
REQ-009 lock_ways_i  in  WAYS  per-way lock bits; a locked way is never selected; sampled on accept.
REQ-010 resp_valid_o  out  1  response available.
REQ-011 resp_ready_i  in  1  consumer accepts the response.
REQ-012 way_oh_o  out  WAYS  one-hot selected way.
REQ-013 way_bin_o  out  $clog2(WAYS)  binary selected way.
REQ-014 resp_invalid_o  out  1  selected way was invalid (no eviction needed).
REQ-015 resp_err_o  out  1  all ways locked; way outputs are zero.

Function
REQ-016 SHALL implement FSM states IDLE, SELECT and RESP.
REQ-017 IDLE: req_ready_o=1; when req_valid_i is high, SHALL capture valid_ways_i and lock_ways_i, clear the try counter and go to SELECT.
REQ-018 SELECT: if any way is unlocked and invalid, SHALL pick the lowest-index such way, set resp_invalid_o=1 and go to RESP.
REQ-019 SELECT: otherwise, if any way is unlocked, the candidate SHALL be lfsr_q[$clog2(WAYS)-1:0].
REQ-020 Candidate unlocked: SHALL be selected and the FSM SHALL go to RESP.
REQ-021 Candidate locked: SHALL increment the try counter and stay in SELECT.
REQ-022 When the try counter reaches MAX_TRIES, SHALL select the lowest-index unlocked way and go to RESP.
REQ-023 SELECT with all ways locked: SHALL set resp_err_o=1, drive way_oh_o=0 and way_bin_o=0, and go to RESP.
REQ-024 LFSR: 8-bit; next = {lfsr_q[6:0], ~(lfsr_q[7]^lfsr_q[3]^lfsr_q[2]^lfsr_q[1])}.
REQ-025 LFSR SHALL step exactly once per SELECT cycle that evaluates a random candidate, whether accepted or rejected; it SHALL hold otherwise.
REQ-026 RESP: resp_valid_o=1; all response outputs SHALL stay stable until resp_ready_i is high; on that handshake, go to IDLE.
REQ-027 req_ready_o SHALL be 0 in SELECT and RESP; no back-to-back bypass.
REQ-028 Latency from accept cycle N: resp_valid_o SHALL rise in cycle N+2 when no retry occurs, plus one cycle per rejected candidate.
REQ-029 way_oh_o SHALL always equal the one-hot decode of way_bin_o, except when resp_err_o=1.
REQ-030 Response outputs SHALL be 0 whenever resp_valid_o=0.

Reset
REQ-031 On rst_i: state IDLE, lfsr_q=SEED, try counter 0, captured masks 0, all response outputs 0, req_ready_o=1 in the first cycle after reset.
REQ-032 rst_i asserted in SELECT or RESP SHALL abort the transaction; no response is produced.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the LFSR tap constant and the MAX_WAYS=8 constant.
REQ-034 The lowest-index one-hot picker SHALL be the sub-module first_one_oh, parameterised by width and used by REQ-018, REQ-022 and REQ-023.
REQ-035 An elaboration-time check SHALL be fatal when WAYS is not 2, 4 or 8.

Verification
REQ-036 WAYS=4, SEED=0, valid=4'b1111, lock=0, four sequential requests -> way_bin_o 0,1,3,2; lfsr_q after each response is 0x01, 0x03, 0x06, 0x0D.
REQ-037 valid=4'b1011, lock=0 -> way_bin_o=2, resp_invalid_o=1, lfsr_q unchanged (0x00), resp_valid_o at N+2.
REQ-038 Right after reset, valid=4'b1111, lock=4'b0001 -> candidate 0 rejected, way_bin_o=1, resp_valid_o at N+3.
REQ-039 lock=4'b1111 -> resp_err_o=1, way_oh_o=0, resp_valid_o at N+2; resp_ready_i held low for 5 cycles -> outputs stable, req_ready_o=0.
REQ-040 MAX_TRIES=1, valid=4'b1111, lock=4'b0011 -> candidate 0 rejected, way_bin_o=2 via fallback at N+3; rst_i pulsed in SELECT of a later request -> no response, lfsr_q=0x00.
